// File: rtl/spi_rx_word_fifo.sv
// SPI receive deserialiser with optional start-bit hunt feeding a show-ahead word FIFO.
// Overflow is sticky and reported; dropped words still produce a WORD_STB pulse.
module spi_rx_word_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int MSB_FIRST  = 1,
    parameter int START_SYNC = 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     CS,
    input  logic                     DI,
    input  logic                     RD_EN,
    input  logic                     CLR_OVF,
    output logic [WIDTH-1:0]         DATA_OUT,
    output logic                     VALID,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     WORD_STB,
    output logic                     OVERFLOW,
    output logic                     SYNCED
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  word_d;
    logic              push;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              stb_q;
    logic              pop, full, accept, drop;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b);
        if (MSB_FIRST != 0) return {v[WIDTH-2:0], b};
        else                return {b, v[WIDTH-1:1]};
    endfunction

    // Framer: with START_SYNC=0 the HUNT state never waits, so framing begins on the first low-CS bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = shift_in(shift_q, DI);
        push    = 1'b0;
        if (CS) begin
            state_d = (START_SYNC != 0) ? HUNT : SHIFT;
            cnt_d   = '0;
            shift_d = '1;
        end else if (state_q == HUNT) begin
            if (!DI || START_SYNC == 0) begin
                state_d = SHIFT;
                cnt_d   = CW'(1);
                shift_d = word_d;
            end
        end else begin
            if (cnt_q == LAST_BIT) begin
                push    = 1'b1;
                cnt_d   = '0;
                shift_d = '1;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                shift_d = word_d;
            end
        end
    end

    assign full   = (level_q == FULL_LVL);
    assign pop    = RD_EN && (level_q != '0);
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_comb begin
        wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (accept && !pop)      level_d = level_q + LW'(1);
        else if (!accept && pop) level_d = level_q - LW'(1);
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (CLR_OVF) ovf_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= HUNT;
            cnt_q    <= '0;
            shift_q  <= '1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            stb_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            stb_q    <= push;
        end
    end

    // Storage carries no reset; DATA_OUT is masked to all-ones whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (accept) mem_q[wr_ptr_q] <= word_d;
    end

    assign VALID    = (level_q != '0);
    assign DATA_OUT = VALID ? mem_q[rd_ptr_q] : '1;
    assign LEVEL    = level_q;
    assign WORD_STB = stb_q;
    assign OVERFLOW = ovf_q;
    assign SYNCED   = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_rx_word_fifo.sv
// Bench for spi_rx_word_fifo: dut0 is MSB-first with start hunt, dut1 is LSB-first without.
// Both share the stimulus; each test only checks the instance it targets.
module tb_spi_rx_word_fifo;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       CS = 1'b1;
    logic       DI = 1'b1;
    logic       RD_EN = 1'b0;
    logic       CLR_OVF = 1'b0;

    logic [7:0] data0, data1;
    logic       valid0, valid1, stb0, stb1, ovf0, ovf1, sync0, sync1;
    logic [2:0] level0, level1;

    int total = 0;
    int bad = 0;
    int stb_cnt0 = 0;
    int stb_cnt1 = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    typedef struct {
        logic [7:0] data;
        logic       clr_last;
        logic [2:0] exp_level;
        logic       exp_ovf;
    } ovf_vec_t;
    ovf_vec_t tbl[5];

    always #5 CLK = ~CLK;

    spi_rx_word_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1), .START_SYNC(1)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .CS(CS), .DI(DI), .RD_EN(RD_EN), .CLR_OVF(CLR_OVF),
        .DATA_OUT(data0), .VALID(valid0), .LEVEL(level0), .WORD_STB(stb0),
        .OVERFLOW(ovf0), .SYNCED(sync0)
    );

    spi_rx_word_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0), .START_SYNC(0)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .CS(CS), .DI(DI), .RD_EN(RD_EN), .CLR_OVF(CLR_OVF),
        .DATA_OUT(data1), .VALID(valid1), .LEVEL(level1), .WORD_STB(stb1),
        .OVERFLOW(ovf1), .SYNCED(sync1)
    );

    always @(negedge CLK) begin
        if (stb0) stb_cnt0 <= stb_cnt0 + 1;
        if (stb1) stb_cnt1 <= stb_cnt1 + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        #2;
        RST_N = 1'b0;
        CS = 1'b1; DI = 1'b1; RD_EN = 1'b0; CLR_OVF = 1'b0;
        q0.delete();
        q1.delete();
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic send_word(input logic [7:0] w, input bit lsb, input bit rd_last, input bit clr_last);
        for (int i = 0; i < 8; i++) begin
            DI      = lsb ? w[i] : w[7-i];
            RD_EN   = rd_last && (i == 7);
            CLR_OVF = clr_last && (i == 7);
            tick();
        end
        RD_EN = 1'b0;
        CLR_OVF = 1'b0;
    endtask

    task automatic pop0(input string name);
        logic [7:0] exp;
        chk({name, "_valid"}, {31'd0, valid0}, 32'd1);
        if (q0.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
            exp = 8'hxx;
        end else begin
            exp = q0.pop_front();
            chk({name, "_data"}, {24'd0, data0}, {24'd0, exp});
        end
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
    endtask

    task automatic pop1(input string name);
        logic [7:0] exp;
        chk({name, "_valid"}, {31'd0, valid1}, 32'd1);
        if (q1.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = q1.pop_front();
            chk({name, "_data"}, {24'd0, data1}, {24'd0, exp});
        end
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
    endtask

    initial begin
        int base;
        logic [7:0] w;

        tbl[0] = '{8'h01, 1'b0, 3'd1, 1'b0};
        tbl[1] = '{8'h02, 1'b0, 3'd2, 1'b0};
        tbl[2] = '{8'h03, 1'b0, 3'd3, 1'b0};
        tbl[3] = '{8'h04, 1'b0, 3'd4, 1'b0};
        tbl[4] = '{8'h05, 1'b1, 3'd4, 1'b1};

        // Reset values before any clock edge
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst_valid", {31'd0, valid0}, 32'd0);
        chk("rst_level", {29'd0, level0}, 32'd0);
        chk("rst_data", {24'd0, data0}, 32'hFF);
        chk("rst_stb", {31'd0, stb0}, 32'd0);
        chk("rst_ovf", {31'd0, ovf0}, 32'd0);
        chk("rst_sync", {31'd0, sync0}, 32'd0);
        tick();
        RST_N = 1'b1;
        tick();

        // Byte with start hunt
        base = stb_cnt0;
        CS = 1'b0;
        for (int i = 0; i < 3; i++) begin
            DI = 1'b1;
            tick();
            chk("hunt_sync_low", {31'd0, sync0}, 32'd0);
        end
        w = 8'h3C;
        q0.push_back(w);
        for (int i = 7; i >= 0; i--) begin
            DI = w[i];
            tick();
            if (i == 7) chk("hunt_sync_rise", {31'd0, sync0}, 32'd1);
            if (i == 1) chk("hunt_no_early_stb", {31'd0, stb0}, 32'd0);
        end
        chk("hunt_stb", {31'd0, stb0}, 32'd1);
        chk("hunt_level", {29'd0, level0}, 32'd1);
        chk("hunt_valid", {31'd0, valid0}, 32'd1);
        CS = 1'b1;
        tick();
        chk("hunt_stb_once", {31'd0, stb0}, 32'd0);
        chk("hunt_stb_count", stb_cnt0 - base, 32'd1);
        pop0("hunt_pop");
        chk("hunt_empty_data", {24'd0, data0}, 32'hFF);

        // LSB-first back-to-back on dut1
        do_reset();
        base = stb_cnt1;
        CS = 1'b0;
        q1.push_back(8'hA5);
        send_word(8'hA5, 1'b1, 1'b0, 1'b0);
        q1.push_back(8'h0F);
        send_word(8'h0F, 1'b1, 1'b0, 1'b0);
        CS = 1'b1;
        tick();
        chk("lsb_level", {29'd0, level1}, 32'd2);
        chk("lsb_stb_count", stb_cnt1 - base, 32'd2);
        pop1("lsb_pop1");
        pop1("lsb_pop2");
        chk("lsb_valid_end", {31'd0, valid1}, 32'd0);
        chk("lsb_data_end", {24'd0, data1}, 32'hFF);
        chk("lsb_level_end", {29'd0, level1}, 32'd0);

        // Overflow, with CLR_OVF colliding with the dropping edge
        do_reset();
        base = stb_cnt0;
        CS = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].exp_ovf == 1'b0) q0.push_back(tbl[i].data);
            send_word(tbl[i].data, 1'b0, 1'b0, tbl[i].clr_last);
            chk($sformatf("ovf_level_%0d", i), {29'd0, level0}, {29'd0, tbl[i].exp_level});
            chk($sformatf("ovf_flag_%0d", i), {31'd0, ovf0}, {31'd0, tbl[i].exp_ovf});
        end
        CS = 1'b1;
        tick();
        chk("ovf_stb_count", stb_cnt0 - base, 32'd5);
        for (int i = 0; i < 4; i++) pop0($sformatf("ovf_pop%0d", i));
        chk("ovf_empty", {31'd0, valid0}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf0}, 32'd1);
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        chk("ovf_cleared", {31'd0, ovf0}, 32'd0);

        // Full FIFO with pop on the completing edge
        do_reset();
        CS = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            q0.push_back(8'(i));
            send_word(8'(i), 1'b0, 1'b0, 1'b0);
        end
        chk("fullrw_level_pre", {29'd0, level0}, 32'd4);
        chk("fullrw_head_pre", {24'd0, data0}, {24'd0, q0[0]});
        void'(q0.pop_front());
        q0.push_back(8'h05);
        send_word(8'h05, 1'b0, 1'b1, 1'b0);
        CS = 1'b1;
        chk("fullrw_ovf", {31'd0, ovf0}, 32'd0);
        chk("fullrw_level", {29'd0, level0}, 32'd4);
        for (int i = 0; i < 4; i++) pop0($sformatf("fullrw_pop%0d", i));
        chk("fullrw_empty", {31'd0, valid0}, 32'd0);

        // CS abort mid-word
        do_reset();
        CS = 1'b0;
        DI = 1'b0; tick();
        DI = 1'b1; tick();
        DI = 1'b0; tick();
        DI = 1'b1; tick();
        DI = 1'b1; tick();
        chk("abort_sync_before", {31'd0, sync0}, 32'd1);
        CS = 1'b1;
        tick();
        chk("abort_sync_cs_high", {31'd0, sync0}, 32'd0);
        chk("abort_sync1_cs_high", {31'd0, sync1}, 32'd1);
        CS = 1'b0;
        q1.push_back(8'h81);
        send_word(8'h81, 1'b1, 1'b0, 1'b0);
        CS = 1'b1;
        tick();
        chk("abort_level1", {29'd0, level1}, 32'd1);
        chk("abort_level0", {29'd0, level0}, 32'd0);
        pop1("abort_pop");
        chk("abort_empty", {31'd0, valid1}, 32'd0);

        // Asynchronous reset between edges
        do_reset();
        CS = 1'b0;
        for (int i = 1; i <= 5; i++) send_word(8'(i), 1'b0, 1'b0, 1'b0);
        CS = 1'b1;
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        chk("arst_level_pre", {29'd0, level0}, 32'd3);
        chk("arst_ovf_pre", {31'd0, ovf0}, 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid0}, 32'd0);
        chk("arst_level", {29'd0, level0}, 32'd0);
        chk("arst_ovf", {31'd0, ovf0}, 32'd0);
        chk("arst_data", {24'd0, data0}, 32'hFF);
        tick();
        RST_N = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_rx_word_fifo.md
Name: spi_rx_word_fifo

Overview:
Parameterised successor to the single-byte SPI receive buffer. It deserialises DI on CLK while CS is low, and can optionally hunt for a leading zero start bit, as SD-card response tokens require. Completed words of WIDTH bits go into a DEPTH-entry show-ahead FIFO. Downstream logic in the same CLK domain drains the FIFO with a valid/read handshake, and overflow is reported instead of silently overwriting data.

Parameters:
WIDTH, 8, bits per received word (2..32)
DEPTH, 4, FIFO entries (power of two, >=2)
MSB_FIRST, 1, 1: first serial bit lands in DATA_OUT[WIDTH-1]; 0: first bit lands in DATA_OUT[0]
START_SYNC, 1, 1: after CS falls, hunt for first DI==0 before framing; 0: frame from first low-CS cycle

Ports:
CLK  in  1  serial/system clock; DI sampled on rising edge
RST_N  in  1  asynchronous active-low reset
CS  in  1  chip select, active-low; high = deselected (synchronous frame abort)
DI  in  1  serial data in
RD_EN  in  1  pop head entry; honoured only while VALID=1
DATA_OUT  out  WIDTH  FIFO head word; all-ones while VALID=0
VALID  out  1  FIFO non-empty
LEVEL  out  $clog2(DEPTH)+1  number of stored words
WORD_STB  out  1  one-cycle pulse per completed word, including dropped words
OVERFLOW  out  1  sticky: a word was dropped because the FIFO was full
CLR_OVF  in  1  synchronous clear of OVERFLOW
SYNCED  out  1  high while framer is in SHIFT state

Behaviour:
- Reset (RST_N=0, async):
  - Framer state = HUNT; bit counter = 0; shift register = all-ones.
  - FIFO empty.
  - VALID=0, LEVEL=0, DATA_OUT=all-ones, WORD_STB=0, OVERFLOW=0, SYNCED=0.
- Framer states: HUNT, SHIFT.
  - CS=1 at any edge: state = HUNT (SHIFT if START_SYNC=0), counter = 0, shift register = all-ones. The partial word is discarded. FIFO contents and OVERFLOW are retained.
  - HUNT, CS=0, DI=0: this bit is the first data bit of the word. Shift it in, counter = 1, go to SHIFT.
  - HUNT, CS=0, DI=1: no change.
  - SHIFT, CS=0: shift DI in, counter += 1.
  - When the bit with counter == WIDTH-1 is sampled, the word is complete. On that same edge: push the word, counter = 0, stay in SHIFT.
  - Subsequent words are contiguous and are not re-hunted.
- Bit order:
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
- Latency: word completes at edge N. After edge N, WORD_STB=1 for exactly one cycle, and the word is visible on DATA_OUT with VALID=1 if the FIFO was empty.
- FIFO: show-ahead. DATA_OUT always reflects the head entry.
  - RD_EN=1 with VALID=1 pops the head at the edge.
  - RD_EN=1 with VALID=0 is ignored.
- Push while not full: accepted; LEVEL += 1.
- Simultaneous push and pop:
  - LEVEL unchanged; ordering preserved.
  - When full, the pop frees a slot, the push is accepted and OVERFLOW is not set.
- Push while full with no pop: word dropped, FIFO unchanged, OVERFLOW set.
- CLR_OVF: clears OVERFLOW; a new overflow in the same cycle wins (OVERFLOW stays 1).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. LEVEL ranges 0..DEPTH.
- SYNCED = (state == SHIFT).
- Reset mid-word or mid-FIFO: everything returns to reset values immediately, without waiting for CLK.

Test Plan:
- Byte with start sync: WIDTH=8, START_SYNC=1, MSB_FIRST=1. CS=0, DI=1,1,1 then serial 0x3C. Expect:
  - SYNCED rises after the first 0 bit.
  - WORD_STB pulses once after the 8th bit.
  - DATA_OUT=0x3C, VALID=1, LEVEL=1.
- LSB-first back-to-back: MSB_FIRST=0, START_SYNC=0. Send serial bits for 0xA5 then 0x0F with no gap, no RD_EN. Expect:
  - LEVEL=2.
  - First pop shows 0xA5; second pop shows 0x0F.
  - VALID=0 and DATA_OUT=0xFF after the second pop.
- Overflow: DEPTH=4. Send 5 words 0x01..0x05 with no reads. Expect:
  - LEVEL=4, OVERFLOW=1, five WORD_STB pulses.
  - Pops return 0x01..0x04.
  - CLR_OVF then drops OVERFLOW to 0.
- Full with simultaneous push/pop: FIFO full with 0x01..0x04. Hold RD_EN=1 on the 5th word's completion edge. Expect:
  - OVERFLOW=0, LEVEL=4.
  - Sequence 0x02..0x05 read out.
- CS abort: raise CS after 5 bits of a word, lower it, then send 0x81. Expect:
  - Only 0x81 is pushed; LEVEL=1.
  - SYNCED=0 during CS high.
- Async reset: assert RST_N=0 between CLK edges with LEVEL=3 and OVERFLOW=1. Expect immediately VALID=0, LEVEL=0, OVERFLOW=0, DATA_OUT=0xFF.
